imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Pipelined, parametrised immediate-extension unit for the datapath decode stage. It takes an IN_W-bit immediate field, extends it to OUT_W bits in one of four modes, and presents the result on a valid/ready interface. The result carries an opaque tag, such as a destination register number, alongside it. A synchronous flush drops in-flight entries on branch redirect, and a wrapping counter records completed transfers.

## Interface
- IN_W, 16, immediate field width; must be at least 2.
- OUT_W, 32, extended result width; must be greater than IN_W.
- TAG_W, 5, width of the sideband tag carried with each entry.
- CNT_W, 16, width of the transfer counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous flush of all in-flight entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  unit can accept an entry this cycle.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of the result.
- xfer_cnt  out  CNT_W  count of output transfers.

## Operation
- Clock is `clk`. Reset is `rst_n`, synchronous and active-low.
- Modes:
  - 0 SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - 1 ZERO: upper bits are 0.
  - 2 HIGH: in_imm << (OUT_W-IN_W), low bits 0; this is the lui form.
  - 3 SHL2: SIGN result << 2, truncated to OUT_W; this is the branch-offset form.
- All modes are pure bit rearrangement. No arithmetic overflow is possible; SHL2 discards the top 2 bits.
- The extension is computed on the input side, and the registered result is stored with its tag.
- Input handshake: an entry is accepted when in_valid && in_ready && !flush.
- Output handshake: an entry transfers when out_valid && out_ready.
- Ordering is strict FIFO.
- xfer_cnt increments by 1 on each output transfer and wraps from all-ones to 0. Dropped entries are not counted.
- flush:
  - In the same cycle, all stored entries are invalidated and no input is accepted, regardless of in_valid.
  - A transfer presented in the flush cycle still counts if out_valid && out_ready.
  - Next cycle: out_valid = 0.
- Reset values: out_valid 0, in_ready 0 during reset and 1 from the first cycle after reset releases, out_data 0, out_tag 0, xfer_cnt 0, all storage invalid.
- Reset asserted mid-operation discards every entry on that edge. The counter clears.
- in_imm, in_mode and in_tag are ignored when in_valid is 0.

## Timing
- Latency: 1 cycle from acceptance to out_valid with the result.
- out_data and out_tag are registered and hold stable while out_valid && !out_ready.
- Throughput: 1 entry per cycle when out_ready stays high.
- Simultaneous accept and transfer in one cycle is legal; occupancy is unchanged.
- Behaviour on stall depends on the configuration; see below.

## Configuration
- Macro: IMM_EXT_SKID_EN.
- Defined (2 entries: output register plus skid register):
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - On a stall with the output register full, one further accepted entry parks in the skid register.
  - When out_ready rises, the skid entry moves to the output on the next edge.
- Undefined (single output register):
  - in_ready = !out_valid || out_ready, a combinational path from out_ready.
  - Capacity is 1 entry.

## Structure
- Shared package imm_ext_pkg holds:
  - mode constants IMM_SIGN=2'd0, IMM_ZERO=2'd1, IMM_HIGH=2'd2, IMM_SHL2=2'd3;
  - the mode typedef;
  - the default width constants for the 16-to-32 datapath.
- Sub-module imm_ext_core: combinational extender parametrised by IN_W and OUT_W, implementing the four modes. It is instantiated once on the input side.
- The top level holds the storage registers, handshake logic, flush handling and counter.

## Test plan
- Mode sweep with out_ready=1, IN_W=16, OUT_W=32: SIGN 0x8000 gives 0xFFFF8000; ZERO 0x8000 gives 0x00008000; HIGH 0x1234 gives 0x12340000; SHL2 0xFFFF gives 0xFFFFFFFC. Each result appears 1 cycle after acceptance with its tag intact.
- Backpressure with SKID_EN:
  - out_ready=0 while 3 entries are offered, tags 1, 2, 3.
  - Tags 1 and 2 are accepted, then in_ready drops.
  - After out_ready rises, outputs are 1 then 2, then tag 3 is accepted.
  - Without SKID_EN, only tag 1 is accepted.
- Flush with 2 entries held and in_valid=1:
  - Next cycle out_valid=0.
  - The input offered in the flush cycle is not accepted.
  - xfer_cnt is unchanged.
- Reset pulse, rst_n low for 1 cycle, with an entry stalled: all outputs return to their reset values, and the next accepted entry emerges normally.
- Counter wrap: preload via CNT_W=4 and perform 17 transfers. xfer_cnt sequence ends 0xF, 0x0, 0x1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: extension modes and
// default widths for the 16-to-32 decode datapath.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SIGN = 2'd0,
    IMM_ZERO = 2'd1,
    IMM_HIGH = 2'd2,
    IMM_SHL2 = 2'd3
  } imm_mode_e;

  localparam int unsigned IMM_IN_W  = 16;
  localparam int unsigned IMM_OUT_W = 32;
  localparam int unsigned IMM_TAG_W = 5;
  localparam int unsigned IMM_CNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: SIGN, ZERO, HIGH (lui) and SHL2 (branch offset).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] ext
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;

  always_comb begin
    sign_ext = {{PAD_W{imm[IN_W-1]}}, imm};
    ext      = sign_ext;
    case (mode)
      IMM_SIGN: ext = sign_ext;
      IMM_ZERO: ext = {{PAD_W{1'b0}}, imm};
      IMM_HIGH: ext = {imm, {PAD_W{1'b0}}};
      IMM_SHL2: ext = {sign_ext[OUT_W-3:0], 2'b00};
      default:  ext = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension unit with valid/ready handshake, flush and transfer counter.
// Define IMM_EXT_SKID_EN for a 2-entry (output + skid) build with registered in_ready.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W,
  parameter int unsigned TAG_W = IMM_TAG_W,
  parameter int unsigned CNT_W = IMM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             accept;
  logic             xfer;
  logic [OUT_W-1:0] ext;
  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt_q;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (imm_mode_e'(in_mode)),
    .ext  (ext)
  );

  assign accept    = in_valid && in_ready && !flush;
  assign xfer      = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign xfer_cnt  = cnt_q;

`ifdef IMM_EXT_SKID_EN
  logic             skid_valid;
  logic             skid_valid_nx;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             rdy_q;

  assign in_ready = rdy_q;

  // Skid only fills when the output register is held; any free output slot drains it.
  always_comb begin
    skid_valid_nx = skid_valid;
    if (flush)
      skid_valid_nx = 1'b0;
    else if (!valid_q || out_ready)
      skid_valid_nx = 1'b0;
    else if (accept)
      skid_valid_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      tag_q      <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
      rdy_q      <= 1'b0;
    end else begin
      skid_valid <= skid_valid_nx;
      rdy_q      <= !skid_valid_nx;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!valid_q || out_ready) begin
        if (skid_valid) begin
          valid_q <= 1'b1;
          data_q  <= skid_data;
          tag_q   <= skid_tag;
        end else begin
          valid_q <= accept;
          if (accept) begin
            data_q <= ext;
            tag_q  <= in_tag;
          end
        end
      end else if (accept) begin
        skid_data <= ext;
        skid_tag  <= in_tag;
      end
    end
  end
`else
  logic rst_done;

  assign in_ready = rst_done && (!valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!valid_q || out_ready) begin
        valid_q <= accept;
        if (accept) begin
          data_q <= ext;
          tag_q  <= in_tag;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (xfer)
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed scenarios plus randomized traffic
// checked against an arithmetic reference of the extension modes.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] xfer_cnt;

  imm_ext_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   out_log[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt_model = 0;
  int   acc_count = 0;
  int   xfer_count = 0;
  bit   armed = 0;
  bit   ready_ok = 0;
  bit   last_accept = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: treat the immediate as a signed/unsigned number and scale it.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    longint r;
    s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
    case (mode)
      2'd0:    r = s;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  always @(negedge clk) begin : monitor
    bit   acc;
    bit   xf;
    bit   exp_rdy;
    exp_t e;
    if (armed) begin
`ifdef IMM_EXT_SKID_EN
      exp_rdy = ready_ok && (sb.size() < 2);
`else
      exp_rdy = ready_ok && (sb.size() == 0 || out_ready);
`endif
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("xfer_cnt", 64'(xfer_cnt), 64'(cnt_model % 16));
    end
    if (!rst_n) begin
      sb.delete();
      cnt_model   = 0;
      ready_ok    = 0;
      last_accept = 0;
      armed       = 1;
    end else if (armed) begin
      xf  = out_valid && out_ready;
      acc = in_valid && in_ready && !flush;
      if (xf) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
        out_log.push_back(int'(out_tag));
        cnt_model = (cnt_model + 1) % 16;
        xfer_count++;
      end
      if (flush) sb.delete();
      if (acc) begin
        sb.push_back('{data: ref_ext(in_imm, in_mode), tag: in_tag});
        acc_count++;
      end
      last_accept = acc;
      ready_ok    = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc();
      done = last_accept;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin : watchdog
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $finish;
  end

  initial begin : driver
    int cnt_before;
    int acc_before;
    int xfer_before;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));

    // Mode sweep with constant expectations, one cycle after acceptance.
    out_ready = 1'b1;
    send(16'h8000, 2'd0, 5'd1);
    @(negedge clk);
    check("sign_data", 64'(out_data), 64'h0000_0000_FFFF_8000);
    check("sign_tag", 64'(out_tag), 64'd1);
    send(16'h8000, 2'd1, 5'd2);
    @(negedge clk);
    check("zero_data", 64'(out_data), 64'h0000_0000_0000_8000);
    send(16'h1234, 2'd2, 5'd3);
    @(negedge clk);
    check("high_data", 64'(out_data), 64'h0000_0000_1234_0000);
    send(16'hFFFF, 2'd3, 5'd4);
    @(negedge clk);
    check("shl2_data", 64'(out_data), 64'h0000_0000_FFFF_FFFC);
    check("shl2_tag", 64'(out_tag), 64'd4);
    repeat (3) cyc();

    // Backpressure: three offers while stalled.
    out_log.delete();
    out_ready  = 1'b0;
    acc_before = acc_count;
    in_valid   = 1'b1;
    in_imm     = 16'h0011; in_mode = 2'd0; in_tag = 5'd1; cyc();
    in_imm     = 16'h0022; in_mode = 2'd1; in_tag = 5'd2; cyc();
    in_imm     = 16'h0033; in_mode = 2'd2; in_tag = 5'd3; cyc();
    cyc();
`ifdef IMM_EXT_SKID_EN
    check("bp_accepted", 64'(acc_count - acc_before), 64'd2);
`else
    check("bp_accepted", 64'(acc_count - acc_before), 64'd1);
`endif
    check("bp_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    send(16'h0033, 2'd2, 5'd3);
    repeat (4) cyc();
`ifdef IMM_EXT_SKID_EN
    check("bp_order_len", 64'(out_log.size()), 64'd3);
    if (out_log.size() == 3) begin
      check("bp_order0", 64'(out_log[0]), 64'd1);
      check("bp_order1", 64'(out_log[1]), 64'd2);
      check("bp_order2", 64'(out_log[2]), 64'd3);
    end
`else
    check("bp_order_len", 64'(out_log.size()), 64'd2);
    if (out_log.size() == 2) begin
      check("bp_order0", 64'(out_log[0]), 64'd1);
      check("bp_order1", 64'(out_log[1]), 64'd3);
    end
`endif

    // Flush while holding entries and offering a new one.
    out_ready = 1'b0;
    send(16'h0A0A, 2'd0, 5'd10);
`ifdef IMM_EXT_SKID_EN
    send(16'h0B0B, 2'd1, 5'd11);
`endif
    cnt_before = int'(xfer_cnt);
    acc_before = acc_count;
    in_valid = 1'b1; in_imm = 16'h0C0C; in_mode = 2'd0; in_tag = 5'd12;
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_no_accept", 64'(acc_count - acc_before), 64'(0));
    check("flush_cnt_hold", 64'(xfer_cnt), 64'(cnt_before));

    // A transfer presented in the flush cycle still counts.
    send(16'h0D0D, 2'd3, 5'd13);
    cnt_before = int'(xfer_cnt);
    out_ready = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("flush_xfer_cnt", 64'(xfer_cnt), 64'((cnt_before + 1) % 16));
    check("flush_xfer_valid", 64'(out_valid), 64'(0));

    // Reset pulse with a stalled entry.
    out_ready = 1'b0;
    send(16'h7777, 2'd1, 5'd20);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rp_out_valid", 64'(out_valid), 64'(0));
    check("rp_out_data", 64'(out_data), 64'(0));
    check("rp_out_tag", 64'(out_tag), 64'(0));
    check("rp_xfer_cnt", 64'(xfer_cnt), 64'(0));
    out_ready = 1'b1;
    send(16'h9001, 2'd0, 5'd21);
    @(negedge clk);
    check("rp_next_valid", 64'(out_valid), 64'(1));
    check("rp_next_tag", 64'(out_tag), 64'd21);
    check("rp_next_data", 64'(out_data), 64'h0000_0000_FFFF_9001);

    // Counter wrap: 17 transfers from a cleared counter.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    xfer_before = xfer_count;
    for (int k = 0; k < 17; k++) send(16'($urandom), 2'($urandom), 5'(k));
    repeat (3) cyc();
    check("wrap_xfers", 64'(xfer_count - xfer_before), 64'd17);
    check("wrap_cnt", 64'(xfer_cnt), 64'd1);

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    check("drain_empty", 64'(sb.size()), 64'(0));

    summary();
    $finish;
  end

endmodule
